// File: rtl/stream_packet_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stream_packet_framer
//  Description : Fixed-length packet framer for a wide AXI-Stream. Incoming
//                beats are cut into packets of cfg_pkt_len_i beats, with
//                TLAST driven on the final beat of each packet. An early
//                upstream TLAST either closes the packet short or, when
//                PadEnable = 1, is followed by zero-filled pad beats up to
//                the full length. The output is a 2-entry skid buffer, so
//                TREADY and all master outputs come from flops.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              sole clock, rising edge
//    reset            synchronous, active-high reset
//    cfg_pkt_len_i    beats per packet (0 behaves as 1), sampled on the
//                     first beat of each packet
//    s_axis_*         slave stream (tdata/tkeep/tlast/tvalid in, tready out)
//    m_axis_*         master stream (tdata/tkeep/tlast/tvalid out, tready in)
//    pkt_count_o      packets completed downstream (tlast handshakes), wraps
//    pad_beats_o      pad beats written into the output buffer, wraps
// ============================================================================
module stream_packet_framer #(
    parameter int StreamWidth = 64,
    parameter int LenWidth    = 16,
    parameter bit PadEnable   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LenWidth-1:0]      cfg_pkt_len_i,
    input  logic [StreamWidth-1:0]   s_axis_tdata_i,
    input  logic [StreamWidth/8-1:0] s_axis_tkeep_i,
    input  logic                     s_axis_tlast_i,
    input  logic                     s_axis_tvalid_i,
    output logic                     s_axis_tready_o,
    output logic [StreamWidth-1:0]   m_axis_tdata_o,
    output logic [StreamWidth/8-1:0] m_axis_tkeep_o,
    output logic                     m_axis_tlast_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic [31:0]              pkt_count_o,
    output logic [31:0]              pad_beats_o
);

    localparam int                  KEEP_WIDTH = StreamWidth / 8;
    localparam logic [LenWidth-1:0] LEN_ONE    = LenWidth'(1);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_PAD  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q,      state_d;
    logic [LenWidth-1:0]   beat_cnt_q,   beat_cnt_d;
    logic [LenWidth-1:0]   cur_len_q,    cur_len_d;
    logic [31:0]           pkt_count_q,  pkt_count_d;
    logic [31:0]           pad_beats_q,  pad_beats_d;

    // Main entry drives the master port directly; skid entry catches the
    // beat written while the main entry is stalled.
    logic                  main_valid_q, main_valid_d;
    logic [StreamWidth-1:0] main_data_q, main_data_d;
    logic [KEEP_WIDTH-1:0] main_keep_q,  main_keep_d;
    logic                  main_last_q,  main_last_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [StreamWidth-1:0] skid_data_q, skid_data_d;
    logic [KEEP_WIDTH-1:0] skid_keep_q,  skid_keep_d;
    logic                  skid_last_q,  skid_last_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   in_accept;
    logic                   out_pop;
    logic [LenWidth-1:0]    len_eff;
    logic                   at_end;
    logic                   pad_end;
    logic                   wr_en;
    logic [StreamWidth-1:0] wr_data;
    logic [KEEP_WIDTH-1:0]  wr_keep;
    logic                   wr_last;

    // Ready depends only on flops, gated off while reset is held so no beat
    // is taken during reset.
    assign s_axis_tready_o = !reset && !skid_valid_q && (state_q == ST_PASS);
    assign in_accept       = s_axis_tvalid_i && s_axis_tready_o;
    assign out_pop         = main_valid_q && m_axis_tready_i;

    // On the first beat of a packet the length comes straight from the
    // config port (0 promoted to 1); afterwards the latched copy is used so
    // mid-packet config changes cannot disturb the current packet.
    always_comb begin
        if (beat_cnt_q == '0) begin
            len_eff = (cfg_pkt_len_i == '0) ? LEN_ONE : cfg_pkt_len_i;
        end else begin
            len_eff = cur_len_q;
        end
    end

    assign at_end  = (beat_cnt_q == (len_eff - LEN_ONE));
    assign pad_end = (beat_cnt_q == (cur_len_q - LEN_ONE));

    // ------------------------------------------------------------------
    // Framing FSM: next state, beat counter, buffer write request
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        cur_len_d   = cur_len_q;
        pad_beats_d = pad_beats_q;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_keep     = '0;
        wr_last     = 1'b0;

        case (state_q)
            ST_PASS: begin
                if (in_accept) begin
                    wr_en     = 1'b1;
                    wr_data   = s_axis_tdata_i;
                    wr_keep   = s_axis_tkeep_i;
                    cur_len_d = len_eff;
                    if (at_end) begin
                        // Full-length close wins over any input tlast, so
                        // a tlast on the last position never pads.
                        wr_last    = 1'b1;
                        beat_cnt_d = '0;
                    end else if (s_axis_tlast_i) begin
                        if (PadEnable) begin
                            wr_last    = 1'b0;
                            beat_cnt_d = beat_cnt_q + LEN_ONE;
                            state_d    = ST_PAD;
                        end else begin
                            wr_last    = 1'b1;
                            beat_cnt_d = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_ONE;
                    end
                end
            end

            ST_PAD: begin
                // Skid empty means the buffer can take one more beat.
                if (!skid_valid_q) begin
                    wr_en       = 1'b1;
                    wr_last     = pad_end;
                    pad_beats_d = pad_beats_q + 32'd1;
                    if (pad_end) begin
                        beat_cnt_d = '0;
                        state_d    = ST_PASS;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output skid buffer and packet counter
    // ------------------------------------------------------------------
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_keep_d  = main_keep_q;
        main_last_d  = main_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        pkt_count_d  = pkt_count_q;

        if (out_pop && main_last_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end

        // A write is only ever requested while the skid entry is empty, so
        // the skid-full branch never has to deal with a new beat.
        if (skid_valid_q) begin
            if (out_pop) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_keep_d  = skid_keep_q;
                main_last_d  = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (wr_en) begin
            if (!main_valid_q || out_pop) begin
                main_valid_d = 1'b1;
                main_data_d  = wr_data;
                main_keep_d  = wr_keep;
                main_last_d  = wr_last;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = wr_data;
                skid_keep_d  = wr_keep;
                skid_last_d  = wr_last;
            end
        end else if (out_pop) begin
            main_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PASS;
            beat_cnt_q   <= '0;
            cur_len_q    <= LEN_ONE;
            pkt_count_q  <= '0;
            pad_beats_q  <= '0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_keep_q  <= '0;
            main_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            cur_len_q    <= cur_len_d;
            pkt_count_q  <= pkt_count_d;
            pad_beats_q  <= pad_beats_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_keep_q  <= main_keep_d;
            main_last_q  <= main_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign m_axis_tvalid_o = main_valid_q;
    assign m_axis_tdata_o  = main_data_q;
    assign m_axis_tkeep_o  = main_keep_q;
    assign m_axis_tlast_o  = main_last_q;
    assign pkt_count_o     = pkt_count_q;
    assign pad_beats_o     = pad_beats_q;

endmodule
`default_nettype wire
